aes_spi_master: RTL and testbench

AES_SPI_MASTER -- requirements
Module: aes_spi_master

---
 rtl/aes_spi_master_if.sv | 39 +++
 rtl/aes_spi_master.sv | 161 ++++++++++++++++
 tb/tb_aes_spi_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_master_if.sv
// Bus between the AES SPI master and its environment: transaction request,
// key/text/result blocks and the serial link to the AES slaves.
// With AES_SPI_MASTER_CHECK_EN defined, the bus also carries expected_in
// and match for the on-chip result comparison.
interface aes_spi_master_if;
  logic         start;
  logic         mode;
  logic [255:0] key_in;
  logic [127:0] text_in;
  logic         mosi;
  logic         miso;
  logic         cs_enc_n;
  logic         cs_dec_n;
  logic         busy;
  logic         done;
  logic [127:0] result_out;
`ifdef AES_SPI_MASTER_CHECK_EN
  logic [127:0] expected_in;
  logic         match;
`endif

  modport master (
`ifdef AES_SPI_MASTER_CHECK_EN
    input  expected_in,
    output match,
`endif
    input  start, mode, key_in, text_in, miso,
    output mosi, cs_enc_n, cs_dec_n, busy, done, result_out
  );

  modport slave (
`ifdef AES_SPI_MASTER_CHECK_EN
    output expected_in,
    input  match,
`endif
    output start, mode, key_in, text_in, miso,
    input  mosi, cs_enc_n, cs_dec_n, busy, done, result_out
  );
endinterface

// File: rtl/aes_spi_master.sv
// SPI master that streams a key and a text block to an AES slave, waits a
// fixed number of idle cycles, then reads a 128-bit result back.
// Optional feature macro: AES_SPI_MASTER_CHECK_EN (compares the received block
// against expected_in and reports it on match).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; captures key/text/mode on acceptance
// SEND_KEY  | shifting out 32*NK key bits, MSB first
// SEND_TEXT | shifting out 128 text bits, MSB first
// WAIT      | mosi low for WAIT_CYCLES cycles while the slave computes
// RECV      | sampling 128 miso bits into the result shift register
// DONE      | one-cycle done pulse, chip select released
module aes_spi_master #(
  parameter int NK          = 4,
  parameter int WAIT_CYCLES = 56
) (
  input logic             clk,
  input logic             reset,
  aes_spi_master_if.master bus
);

  localparam int KW = 32 * NK;

  typedef enum logic [2:0] {
    IDLE, SEND_KEY, SEND_TEXT, WAIT, RECV, DONE
  } state_t;

  state_t       state, state_nxt;
  logic [8:0]   bit_cnt;
  logic [7:0]   wait_cnt;
  logic [383:0] tx_sreg;
  logic [383:0] tx_cat;
  logic [383:0] tx_load;
  logic [127:0] rx_sreg;
  logic [127:0] rx_next;
  logic [127:0] result_q;
  logic         mosi_q;
  logic         cs_enc_q;
  logic         cs_dec_q;
  logic         busy_q;
  logic         done_q;
`ifdef AES_SPI_MASTER_CHECK_EN
  logic [127:0] expected_q;
  logic         match_q;
`endif

  // Key (only its used top words) followed by the text, left-aligned so the
  // next bit to send is always at bit 383.
  assign tx_cat  = 384'({bus.key_in[255 -: KW], bus.text_in});
  assign tx_load = tx_cat << (256 - KW);
  assign rx_next = {rx_sreg[126:0], bus.miso};

  // Next-state decode; counters reaching zero end each phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.start)      state_nxt = SEND_KEY;
      SEND_KEY:  if (bit_cnt == '0)  state_nxt = SEND_TEXT;
      SEND_TEXT: if (bit_cnt == '0)  state_nxt = WAIT;
      WAIT:      if (wait_cnt == '0) state_nxt = RECV;
      RECV:      if (bit_cnt == '0)  state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // State register plus registered busy/done derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == SEND_KEY) || (state_nxt == SEND_TEXT) ||
                (state_nxt == WAIT) || (state_nxt == RECV);
      done_q <= (state_nxt == DONE);
    end
  end

  // Datapath: shift registers, down-counters, mosi and chip selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      tx_sreg    <= '0;
      rx_sreg    <= '0;
      result_q   <= '0;
      mosi_q     <= 1'b0;
      cs_enc_q   <= 1'b1;
      cs_dec_q   <= 1'b1;
`ifdef AES_SPI_MASTER_CHECK_EN
      expected_q <= '0;
      match_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // mosi is registered, so the first key bit is presented now and
            // the shift register keeps the remaining bits.
            tx_sreg  <= tx_load << 1;
            mosi_q   <= tx_load[383];
            bit_cnt  <= 9'(KW - 1);
            cs_enc_q <= bus.mode;
            cs_dec_q <= ~bus.mode;
`ifdef AES_SPI_MASTER_CHECK_EN
            expected_q <= bus.expected_in;
`endif
          end
        end
        SEND_KEY: begin
          mosi_q  <= tx_sreg[383];
          tx_sreg <= tx_sreg << 1;
          bit_cnt <= (bit_cnt == '0) ? 9'd127 : bit_cnt - 9'd1;
        end
        SEND_TEXT: begin
          if (bit_cnt == '0) begin
            mosi_q   <= 1'b0;
            wait_cnt <= 8'(WAIT_CYCLES - 1);
          end else begin
            mosi_q  <= tx_sreg[383];
            tx_sreg <= tx_sreg << 1;
            bit_cnt <= bit_cnt - 9'd1;
          end
        end
        WAIT: begin
          mosi_q <= 1'b0;
          if (wait_cnt == '0) bit_cnt  <= 9'd127;
          else                wait_cnt <= wait_cnt - 8'd1;
        end
        RECV: begin
          rx_sreg <= rx_next;
          if (bit_cnt == '0) begin
            result_q <= rx_next;
            cs_enc_q <= 1'b1;
            cs_dec_q <= 1'b1;
`ifdef AES_SPI_MASTER_CHECK_EN
            match_q  <= (rx_next == expected_q);
`endif
          end else begin
            bit_cnt <= bit_cnt - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mosi       = mosi_q;
  assign bus.cs_enc_n   = cs_enc_q;
  assign bus.cs_dec_n   = cs_dec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result_out = result_q;
`ifdef AES_SPI_MASTER_CHECK_EN
  assign bus.match      = match_q;
`endif

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: an NK=4 and an NK=8 instance share clock and
// reset. A behavioural slave in the bench records the mosi stream against the
// expected key/text bit order and returns a chosen response block on miso.
module tb_aes_spi_master;
  logic clk;
  logic reset;

  aes_spi_master_if bus4();
  aes_spi_master_if bus8();

  aes_spi_master #(.NK(4), .WAIT_CYCLES(56)) dut4 (.clk(clk), .reset(reset), .bus(bus4.master));
  aes_spi_master #(.NK(8), .WAIT_CYCLES(56)) dut8 (.clk(clk), .reset(reset), .bus(bus8.master));

  logic         start_d [2];
  logic         mode_d  [2];
  logic         miso_d  [2];
  logic [255:0] key_d   [2];
  logic [127:0] text_d  [2];
  logic [127:0] exp_d   [2];
  logic         mosi_o  [2];
  logic         cs_enc_o[2];
  logic         cs_dec_o[2];
  logic         busy_o  [2];
  logic         done_o  [2];
  logic [127:0] res_o   [2];
  logic         match_o [2];

  assign bus4.start   = start_d[0];
  assign bus4.mode    = mode_d[0];
  assign bus4.miso    = miso_d[0];
  assign bus4.key_in  = key_d[0];
  assign bus4.text_in = text_d[0];
  assign bus8.start   = start_d[1];
  assign bus8.mode    = mode_d[1];
  assign bus8.miso    = miso_d[1];
  assign bus8.key_in  = key_d[1];
  assign bus8.text_in = text_d[1];

  assign mosi_o[0]   = bus4.mosi;
  assign cs_enc_o[0] = bus4.cs_enc_n;
  assign cs_dec_o[0] = bus4.cs_dec_n;
  assign busy_o[0]   = bus4.busy;
  assign done_o[0]   = bus4.done;
  assign res_o[0]    = bus4.result_out;
  assign mosi_o[1]   = bus8.mosi;
  assign cs_enc_o[1] = bus8.cs_enc_n;
  assign cs_dec_o[1] = bus8.cs_dec_n;
  assign busy_o[1]   = bus8.busy;
  assign done_o[1]   = bus8.done;
  assign res_o[1]    = bus8.result_out;
`ifdef AES_SPI_MASTER_CHECK_EN
  assign bus4.expected_in = exp_d[0];
  assign bus8.expected_in = exp_d[1];
  assign match_o[0] = bus4.match;
  assign match_o[1] = bus8.match;
`else
  assign match_o[0] = 1'b0;
  assign match_o[1] = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic sel_cs(input int inst, input bit m);
    return m ? cs_dec_o[inst] : cs_enc_o[inst];
  endfunction

  // One full transaction with the behavioural slave. exp_lat is the number of
  // falling edges from the call until the selected cs is seen low.
  task automatic run_txn(input int inst, input bit m, input logic [255:0] key,
                         input logic [127:0] text, input logic [127:0] resp,
                         input logic [127:0] expv, input bit hold,
                         input bit pulse_recv, input int exp_lat);
    int kw, base, total, waited, c;
    int stream_err, other_err, busy_err, done_err, idle_err;
    kw = (inst == 1) ? 256 : 128;
    base = kw + 128;
    total = base + 56 + 128;
    stream_err = 0; other_err = 0; busy_err = 0; done_err = 0; idle_err = 0;
    start_d[inst] = 1'b1;
    mode_d[inst]  = m;
    key_d[inst]   = key;
    text_d[inst]  = text;
    exp_d[inst]   = expv;
    miso_d[inst]  = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (sel_cs(inst, m) !== 1'b0 && waited < 10);
    chk("accept_latency", 256'(waited), 256'(exp_lat));
    if (!hold) start_d[inst] = 1'b0;
    // Inputs changing after acceptance must not disturb the transfer.
    mode_d[inst] = ~m;
    text_d[inst] = {$urandom, $urandom, $urandom, $urandom};
    key_d[inst]  = {8{$urandom}};
    for (c = 0; c < 1000; c++) begin
      if (sel_cs(inst, m) !== 1'b0) break;
      if (sel_cs(inst, ~m) !== 1'b1) other_err++;
      if (busy_o[inst] !== 1'b1) busy_err++;
      if (done_o[inst] !== 1'b0) done_err++;
      if (c < kw) begin
        if (mosi_o[inst] !== key[255 - c]) stream_err++;
      end else if (c < base) begin
        if (mosi_o[inst] !== text[127 - (c - kw)]) stream_err++;
      end else begin
        if (mosi_o[inst] !== 1'b0) stream_err++;
      end
      if (c >= base + 56 && c < total) miso_d[inst] = resp[127 - (c - base - 56)];
      else miso_d[inst] = 1'b0;
      if (pulse_recv && c == base + 60) start_d[inst] = 1'b1;
      if (pulse_recv && c == base + 61) start_d[inst] = 1'b0;
      @(negedge clk);
    end
    miso_d[inst] = 1'b0;
    chk("cs_low_cycles", 256'(c), 256'(total));
    chk("mosi_stream_errors", 256'(stream_err), 256'(0));
    chk("unselected_cs_errors", 256'(other_err), 256'(0));
    chk("busy_errors", 256'(busy_err), 256'(0));
    chk("early_done", 256'(done_err), 256'(0));
    chk("done_pulse", 256'(done_o[inst]), 256'(1));
    chk("busy_in_done", 256'(busy_o[inst]), 256'(0));
    chk("cs_released", 256'({cs_enc_o[inst], cs_dec_o[inst]}), 256'(2'b11));
    chk("result", 256'(res_o[inst]), 256'(resp));
`ifdef AES_SPI_MASTER_CHECK_EN
    chk("match", 256'(match_o[inst]), 256'(resp == expv));
`endif
    if (!hold) begin
      repeat (3) begin
        @(negedge clk);
        if (cs_enc_o[inst] !== 1'b1 || cs_dec_o[inst] !== 1'b1 || done_o[inst] !== 1'b0)
          idle_err++;
      end
      chk("idle_after_done", 256'(idle_err), 256'(0));
      chk("result_held", 256'(res_o[inst]), 256'(resp));
    end
  endtask

  localparam logic [127:0] KEY128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [255:0] k;
    logic [127:0] t, r, e;
    int done_seen;
    for (int i = 0; i < 2; i++) begin
      start_d[i] = 1'b0; mode_d[i] = 1'b0; miso_d[i] = 1'b0;
      key_d[i] = '0; text_d[i] = '0; exp_d[i] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs", 256'({cs_enc_o[i], cs_dec_o[i]}), 256'(2'b11));
      chk("rst_mosi_busy_done", 256'({mosi_o[i], busy_o[i], done_o[i]}), 256'(0));
      chk("rst_result", 256'(res_o[i]), 256'(0));
    end
    reset = 1'b0;
    @(negedge clk);

    // Known-answer encrypt, NK=4, junk in the ignored low key bits.
    run_txn(0, 1'b0, {KEY128, 128'hdeadbeef_cafef00d_12345678_9abcdef0}, PT, CT128, CT128, 0, 0, 1);
    run_txn(0, 1'b0, {KEY128, 128'h0}, PT, CT128, 128'h0, 0, 0, 1);
    // Known-answer decrypt, NK=8.
    run_txn(1, 1'b1, KEY256, CT256, PT, PT, 0, 0, 1);
    // Bit order: single key MSB, slave returns a single leading one.
    k = 256'h1 << 255;
    run_txn(1, 1'b0, k, 128'h0, 128'h1 << 127, 128'h0, 0, 0, 1);

    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      t = {$urandom, $urandom, $urandom, $urandom};
      r = {$urandom, $urandom, $urandom, $urandom};
      e = (i % 3 == 0) ? r : {$urandom, $urandom, $urandom, $urandom};
      run_txn(i % 2, 1'($urandom_range(0, 1)), k, t, r, e, 0, 0, 1);
    end

    // start pulsed during RECV is dropped.
    run_txn(0, 1'b1, {8{$urandom}}, {4{$urandom}}, {4{$urandom}}, 128'h0, 0, 1, 1);

    // start held high: back-to-back with one DONE and one IDLE cycle between.
    run_txn(1, 1'b0, {8{$urandom}}, {4{$urandom}}, {4{$urandom}}, 128'h0, 1, 0, 1);
    run_txn(1, 1'b1, {8{$urandom}}, {4{$urandom}}, {4{$urandom}}, 128'h0, 0, 0, 2);

    // Reset in the middle of an NK=8 transaction, with start high during reset.
    start_d[1] = 1'b1; mode_d[1] = 1'b0; key_d[1] = {8{$urandom}}; text_d[1] = {4{$urandom}};
    @(negedge clk);
    start_d[1] = 1'b0;
    repeat (199) @(negedge clk);
    chk("pre_reset_cs_low", 256'(cs_enc_o[1]), 256'(0));
    reset = 1'b1;
    start_d[1] = 1'b1;
    @(negedge clk);
    chk("abort_cs", 256'({cs_enc_o[1], cs_dec_o[1]}), 256'(2'b11));
    chk("abort_busy_done", 256'({busy_o[1], done_o[1], mosi_o[1]}), 256'(0));
    chk("abort_result", 256'(res_o[1]), 256'(0));
    reset = 1'b0;
    start_d[1] = 1'b0;
    done_seen = 0;
    repeat (700) begin
      @(negedge clk);
      if (done_o[1] !== 1'b0 || cs_enc_o[1] !== 1'b1 || cs_dec_o[1] !== 1'b1) done_seen++;
    end
    chk("no_activity_after_abort", 256'(done_seen), 256'(0));
    run_txn(1, 1'b0, KEY256, PT, CT128, CT128, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
